ika9958_hseq: RTL and testbench
===============================

Name: ika9958_hseq

Overview:
Parametrised horizontal timing sequencer, the successor to the fixed common-PLA counter. It holds a split fine/coarse position counter; the fine part counts pixels within a tile and the coarse part counts tiles. Tile length is selectable by mode (graphic/text), and the line-sync reload value is configurable. It also provides NUM_DEC programmable, mode-masked position decoders and an active-display window latch. It sits between reset/clock control and the VRAM/pixel sequencers, which consume its decode strobes.

Parameters:
LO_W, 4, fine (pixel-in-tile) counter width
HI_W, 5, coarse (tile) counter width
NUM_DEC, 8, number of position decode channels
GFX_TILE, 16, fine period in graphic mode (2..2^LO_W)
TXT_TILE, 12, fine period in text mode (2..2^LO_W)
SYNC_LO, 1, fine value loaded on line sync
SYNC_HI, 5'h1F, coarse value loaded on line sync

Ports:
phiA  in  1  master clock; all state on rising edge
RST_async_n  in  1  asynchronous active-low reset
phiL_NCEN  in  1  clock enable; state advances only when 1
line_sync  in  1  horizontal sync event (hadd_eq23 equivalent)
txt_mode  in  1  1 = text mode (TXT_TILE), 0 = graphic (GFX_TILE)
win_start  in  LO_W+HI_W  position that opens the active window
win_stop  in  LO_W+HI_W  position that closes the active window
dec_val  in  NUM_DEC*(LO_W+HI_W)  per-channel compare position, channel i at [i*W +: W]
dec_en_txt  in  NUM_DEC  channel i enabled in text mode
dec_en_gfx  in  NUM_DEC  channel i enabled in graphic mode
cnt  out  LO_W+HI_W  {hi,lo} current position
tile_stb  out  1  registered pulse: fine counter wrapped
hi_wrap  out  1  registered pulse: coarse counter wrapped from all-ones to 0
active  out  1  active-window flag
dec  out  NUM_DEC  registered decode strobes

Behaviour:
- Reset (async, RST_async_n=0): lo=0, hi=0, sync_z=0, active=0, tile_stb=0, hi_wrap=0, dec=0. Release takes effect at the next enabled edge.
- Nothing changes when phiL_NCEN=0. "Step" below means an edge with phiL_NCEN=1.
- tile_len = txt_mode ? TXT_TILE : GFX_TILE, evaluated combinationally each step.
- sync_z <= line_sync every step, giving one step of latency, as in the legacy block.
- Priority per step:
  1. sync_z=1: lo<=SYNC_LO, hi<=SYNC_HI, active<=0, tile_stb<=0, hi_wrap<=0.
  2. Else if lo >= tile_len-1 (terminal): lo<=0, hi<=hi+1 mod 2^HI_W, tile_stb<=1. hi_wrap<=1 iff hi was all-ones.
  3. Else: lo<=lo+1, tile_stb<=0, hi_wrap<=0.
- The ">=" terminal test covers a mode switch mid-tile. If lo already exceeds the new tile_len-1, the next step wraps. lo never runs past tile_len-1 more than once.
- Window, evaluated on the current cnt when sync_z=0:
  - cnt==win_stop: active<=0. Stop wins if win_start==win_stop.
  - Else cnt==win_start: active<=1.
  - Else hold.
  - Latency: active rises one step after cnt equals win_start.
- Decoders: dec[i] <= (cnt==dec_val[i]) & (txt_mode ? dec_en_txt[i] : dec_en_gfx[i]). Registered one step after the match, one step wide per match. Evaluated on the pre-update cnt, including during a sync step.
- Positions never reached with the current tile_len (lo >= tile_len) never decode. This is not an error.
- A line_sync held high for N steps holds the counter at {SYNC_HI,SYNC_LO} for N steps, then counting resumes.
- Mid-operation reset returns all outputs to their reset values immediately, regardless of phiL_NCEN.
- All arithmetic is unsigned, modulo the field width. There is no carry from hi into any other state.

Test Plan:
- Reset, then phiL_NCEN=1, graphic mode, 40 steps → cnt goes 0..15, then 16 (hi=1, lo=0); tile_stb pulses at steps 16 and 32.
- txt_mode=1 from reset → lo wraps after 11. Switch to graphic with lo=7 → counts on to 15. Switch to text with lo=14 → next step lo=0, hi+1, tile_stb=1.
- line_sync pulsed 1 step at arbitrary cnt → two steps after assertion cnt={5'h1F,4'h1} and active=0. Next tile wrap from hi=1F gives hi=0 and hi_wrap=1.
- win_start=0x020, win_stop=0x140 → active=1 one step after cnt=0x020, 0 one step after cnt=0x140. With win_start=win_stop, active stays 0.
- dec_val[3]=0x017, dec_en_gfx[3]=1, dec_en_txt[3]=0 → graphic: dec[3] is a single pulse the step after cnt=0x017. Text: no pulse. dec_val=0x01E in text mode never fires.
- phiL_NCEN toggled 1/0 alternately, plus RST_async_n asserted mid-tile asynchronously → state frozen on disabled edges; outputs 0 immediately on reset with no clock.

Source files
------------

// File: rtl/ika9958_hseq.sv
// Horizontal timing sequencer: split fine/coarse position counter with mode-selectable
// tile length, line-sync reload, an active-display window latch and masked position decoders.
module ika9958_hseq #(
  parameter int LO_W     = 4,
  parameter int HI_W     = 5,
  parameter int NUM_DEC  = 8,
  parameter int GFX_TILE = 16,
  parameter int TXT_TILE = 12,
  parameter int SYNC_LO  = 1,
  parameter int SYNC_HI  = 'h1F
) (
  input  logic                          phiA,
  input  logic                          RST_async_n,
  input  logic                          phiL_NCEN,
  input  logic                          line_sync,
  input  logic                          txt_mode,
  input  logic [LO_W+HI_W-1:0]          win_start,
  input  logic [LO_W+HI_W-1:0]          win_stop,
  input  logic [NUM_DEC*(LO_W+HI_W)-1:0] dec_val,
  input  logic [NUM_DEC-1:0]            dec_en_txt,
  input  logic [NUM_DEC-1:0]            dec_en_gfx,
  output logic [LO_W+HI_W-1:0]          cnt,
  output logic                          tile_stb,
  output logic                          hi_wrap,
  output logic                          active,
  output logic [NUM_DEC-1:0]            dec
);

  localparam int W = LO_W + HI_W;

  logic [LO_W-1:0]    lo;
  logic [HI_W-1:0]    hi;
  logic               sync_z;
  logic [LO_W:0]      tile_last;
  logic               terminal;
  logic [NUM_DEC-1:0] dec_en;
  logic [NUM_DEC-1:0] dec_next;

  assign cnt = {hi, lo};

  // One extra bit so a full 2^LO_W tile length still fits; ">=" also catches a mid-tile
  // switch to a shorter tile that leaves lo already past the new terminal value.
  assign tile_last = txt_mode ? (LO_W+1)'(TXT_TILE - 1) : (LO_W+1)'(GFX_TILE - 1);
  assign terminal  = {1'b0, lo} >= tile_last;
  assign dec_en    = txt_mode ? dec_en_txt : dec_en_gfx;

  always_comb begin
    dec_next = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      dec_next[i] = (cnt == dec_val[i*W +: W]) & dec_en[i];
    end
  end

  always_ff @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      lo       <= '0;
      hi       <= '0;
      sync_z   <= 1'b0;
      active   <= 1'b0;
      tile_stb <= 1'b0;
      hi_wrap  <= 1'b0;
      dec      <= '0;
    end else if (phiL_NCEN) begin
      sync_z <= line_sync;
      dec    <= dec_next;
      if (sync_z) begin
        lo       <= LO_W'(SYNC_LO);
        hi       <= HI_W'(SYNC_HI);
        active   <= 1'b0;
        tile_stb <= 1'b0;
        hi_wrap  <= 1'b0;
      end else begin
        // Stop has priority so a degenerate window (start == stop) never opens.
        if (cnt == win_stop) begin
          active <= 1'b0;
        end else if (cnt == win_start) begin
          active <= 1'b1;
        end
        if (terminal) begin
          lo       <= '0;
          hi       <= hi + HI_W'(1);
          tile_stb <= 1'b1;
          hi_wrap  <= &hi;
        end else begin
          lo       <= lo + LO_W'(1);
          tile_stb <= 1'b0;
          hi_wrap  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ika9958_hseq.sv
// Self-checking bench for ika9958_hseq: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a position-arithmetic model.
module tb_ika9958_hseq;

  localparam int W = 9;
  localparam int ND = 8;

  logic          phiA = 1'b0;
  logic          RST_async_n = 1'b1;
  logic          phiL_NCEN = 1'b0;
  logic          line_sync = 1'b0;
  logic          txt_mode = 1'b0;
  logic [W-1:0]  win_start = 9'h020;
  logic [W-1:0]  win_stop = 9'h140;
  logic [ND*W-1:0] dec_val = '0;
  logic [ND-1:0] dec_en_txt = 8'h00;
  logic [ND-1:0] dec_en_gfx = 8'h00;
  logic [W-1:0]  cnt;
  logic          tile_stb;
  logic          hi_wrap;
  logic          active;
  logic [ND-1:0] dec;

  int checks = 0;
  int fails = 0;
  bit checking = 1'b0;

  int m_lo = 0, m_hi = 0, m_syncz = 0, m_active = 0, m_tile = 0, m_wrap = 0;
  logic [ND-1:0] m_dec = '0;

  ika9958_hseq dut (
    .phiA(phiA), .RST_async_n(RST_async_n), .phiL_NCEN(phiL_NCEN),
    .line_sync(line_sync), .txt_mode(txt_mode),
    .win_start(win_start), .win_stop(win_stop),
    .dec_val(dec_val), .dec_en_txt(dec_en_txt), .dec_en_gfx(dec_en_gfx),
    .cnt(cnt), .tile_stb(tile_stb), .hi_wrap(hi_wrap), .active(active), .dec(dec)
  );

  always #5 phiA = ~phiA;

  // Reference: position as plain integers, tile length 12 or 16, 32 tiles per wrap.
  task automatic modelStep();
    int pos;
    int tlen;
    logic [ND-1:0] en;
    pos  = m_hi * 16 + m_lo;
    tlen = txt_mode ? 12 : 16;
    en   = txt_mode ? dec_en_txt : dec_en_gfx;
    for (int i = 0; i < ND; i++) m_dec[i] = (pos == int'(dec_val[i*W +: W])) && en[i];
    if (m_syncz != 0) begin
      m_lo = 1; m_hi = 31; m_active = 0; m_tile = 0; m_wrap = 0;
    end else begin
      if (pos == int'(win_stop)) m_active = 0;
      else if (pos == int'(win_start)) m_active = 1;
      if (m_lo >= tlen - 1) begin
        m_wrap = (m_hi == 31) ? 1 : 0;
        m_lo = 0;
        m_hi = (m_hi + 1) % 32;
        m_tile = 1;
      end else begin
        m_lo = m_lo + 1; m_tile = 0; m_wrap = 0;
      end
    end
    m_syncz = line_sync ? 1 : 0;
  endtask

  always @(posedge phiA or negedge RST_async_n) begin
    if (!RST_async_n) begin
      m_lo = 0; m_hi = 0; m_syncz = 0; m_active = 0; m_tile = 0; m_wrap = 0; m_dec = '0;
    end else if (phiL_NCEN) begin
      modelStep();
    end
  end

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkEq("cnt", 32'(cnt), 32'(m_hi * 16 + m_lo));
    checkEq("tile_stb", 32'(tile_stb), 32'(m_tile));
    checkEq("hi_wrap", 32'(hi_wrap), 32'(m_wrap));
    checkEq("active", 32'(active), 32'(m_active));
    checkEq("dec", 32'(dec), 32'(m_dec));
  endtask

  always @(negedge phiA) if (checking) checkOutput();

  task automatic applyStimulus();
    if (!RST_async_n) RST_async_n = 1'b1;
    else if ($urandom_range(0, 499) == 0) RST_async_n = 1'b0;
    phiL_NCEN = ($urandom_range(0, 3) != 0);
    line_sync = ($urandom_range(0, 59) == 0);
    if ($urandom_range(0, 39) == 0) txt_mode = ~txt_mode;
    if ($urandom_range(0, 299) == 0) begin
      case ($urandom_range(0, 2))
        0: begin win_start = 9'h020; win_stop = 9'h140; end
        1: begin win_start = 9'h050; win_stop = 9'h050; end
        default: begin win_start = 9'($urandom); win_stop = 9'($urandom); end
      endcase
    end
    if ($urandom_range(0, 199) == 0) begin
      for (int i = 0; i < ND; i++) if (i != 3 && i != 5) dec_val[i*W +: W] = 9'($urandom);
      dec_en_txt = 8'($urandom) | 8'h20;
      dec_en_gfx = (8'($urandom) | 8'h08);
    end
  endtask

  initial begin
    dec_val[3*W +: W] = 9'h017;
    dec_val[5*W +: W] = 9'h01E;
    dec_en_gfx = 8'h08;
    dec_en_txt = 8'h20;
    #2 RST_async_n = 1'b0;
    #1 checking = 1'b1;
    checkEq("reset_cnt", 32'(cnt), 32'h0);
    @(negedge phiA); #1 RST_async_n = 1'b1;
    repeat (3) @(negedge phiA);
    #1 checkEq("frozen_cnt", 32'(cnt), 32'h0);

    // Graphic mode: 16 pixels per tile.
    phiL_NCEN = 1'b1;
    repeat (16) @(negedge phiA);
    #1 checkEq("gfx_step16_cnt", 32'(cnt), 32'h010);
    checkEq("gfx_step16_stb", 32'(tile_stb), 32'h1);
    repeat (16) @(negedge phiA);
    #1 checkEq("gfx_step32_cnt", 32'(cnt), 32'h020);
    checkEq("gfx_step32_stb", 32'(tile_stb), 32'h1);
    checkEq("win_open", 32'(active), 32'h0);
    @(negedge phiA);
    #1 checkEq("win_open_late", 32'(active), 32'h1);

    // One-step line sync reloads two steps after assertion; next wrap from 1F sets hi_wrap.
    line_sync = 1'b1;
    @(negedge phiA); #1 line_sync = 1'b0;
    @(negedge phiA);
    #1 checkEq("sync_cnt", 32'(cnt), 32'h1F1);
    checkEq("sync_active", 32'(active), 32'h0);
    repeat (15) @(negedge phiA);
    #1 checkEq("wrap_cnt", 32'(cnt), 32'h000);
    checkEq("wrap_flag", 32'(hi_wrap), 32'h1);

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    repeat (5) @(negedge phiA);
    #3 RST_async_n = 1'b0;
    #1 checkEq("async_cnt", 32'(cnt), 32'h0);
    checkEq("async_stb", 32'(tile_stb), 32'h0);
    checkEq("async_active", 32'(active), 32'h0);

    // Text mode tiles, then mode switches mid-tile.
    @(negedge phiA); #1 RST_async_n = 1'b1; txt_mode = 1'b1;
    repeat (12) @(negedge phiA);
    #1 checkEq("txt_step12_cnt", 32'(cnt), 32'h010);
    repeat (7) @(negedge phiA);
    #1 checkEq("txt_lo7_cnt", 32'(cnt), 32'h017);
    txt_mode = 1'b0;
    @(negedge phiA);
    #1 checkEq("dec3_gfx", 32'(dec), 32'h08);
    repeat (6) @(negedge phiA);
    #1 checkEq("gfx_lo14_cnt", 32'(cnt), 32'h01E);
    txt_mode = 1'b1;
    @(negedge phiA);
    #1 checkEq("switch_wrap_cnt", 32'(cnt), 32'h020);
    checkEq("switch_wrap_stb", 32'(tile_stb), 32'h1);

    // Alternating clock enable.
    for (int k = 0; k < 40; k++) begin
      @(negedge phiA); #1 phiL_NCEN = ~phiL_NCEN;
    end

    for (int k = 0; k < 3000; k++) begin
      @(negedge phiA); #1 applyStimulus();
    end
    @(negedge phiA); #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
